fpdiv_iterative: RTL and testbench

Multi-cycle FP32 divider (out = A / B) for the FPU datapath, alongside the pipelined adder. It uses a start/busy/done handshake and a one-bit-per-cycle restoring mantissa divider. Inputs are normal FP32 (0 < exp < 255) or exact zero. Results never overflow or underflow, so no NaN, subnormal or range checks are made. Rounding is truncation (round toward zero).

---
 rtl/fp32_pkg.sv | 28 ++
 rtl/fpdiv_restoring_step.sv | 20 ++
 rtl/fpdiv_iterative.sv | 98 +++++++++
 tb/tb_fpdiv_iterative.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// fp32_pkg: shared FP32 constants, field unpacking and divider FSM states.
//   EXP_BIAS, EXP_W, MAN_W, FP32_PINF : format constants
//   fp_fields_t / fp_unpack           : sign, exponent, mantissa with hidden bit, zero flag
//   state_t                           : IDLE / DIV / NORM sequencing of fpdiv_iterative
package fp32_pkg;
    localparam int EXP_BIAS = 127;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam logic [31:0] FP32_PINF = 32'h7F80_0000;

    typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   man;
        logic             zero;
    } fp_fields_t;

    // Operands are normal or exact zero, so the hidden bit is always forced to 1;
    // the zero flag alone decides whether the mantissa is meaningful.
    function automatic fp_fields_t fp_unpack(input logic [31:0] x);
        fp_unpack.sign = x[31];
        fp_unpack.exp  = x[30:23];
        fp_unpack.man  = {1'b1, x[22:0]};
        fp_unpack.zero = (x[30:0] == 31'h0);
    endfunction
endpackage

// File: rtl/fpdiv_restoring_step.sv
// fpdiv_restoring_step: one combinational restoring-division iteration.
//   r      : partial remainder (25 b)
//   mb     : divisor mantissa with hidden bit (24 b)
//   r_next : remainder for the next iteration, already shifted left
//   q_bit  : quotient bit produced by this iteration
module fpdiv_restoring_step
    import fp32_pkg::*;
(
    input  logic [MAN_W+1:0] r,
    input  logic [MAN_W:0]   mb,
    output logic [MAN_W+1:0] r_next,
    output logic             q_bit
);
    logic [MAN_W+1:0] diff;

    // r stays below 2*mb, so the shifted remainder always fits in 25 bits.
    assign q_bit  = (r >= {1'b0, mb});
    assign diff   = r - {1'b0, mb};
    assign r_next = (q_bit ? diff : r) << 1;
endmodule

// File: rtl/fpdiv_iterative.sv
// fpdiv_iterative: multi-cycle FP32 divider, out = reg_A / reg_B, truncating.
//   clk, reset(async active-low)
//   start, reg_A, reg_B : request and operands, taken only while idle
//   busy                : operation in flight
//   done                : one-cycle pulse when out / div_by_zero update
//   out, div_by_zero    : quotient and divide-by-zero flag, held until next done
module fpdiv_iterative
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] reg_A,
    input  logic [31:0] reg_B,
    output logic        busy,
    output logic        done,
    output logic [31:0] out,
    output logic        div_by_zero
);
    state_t           state, state_n;
    fp_fields_t       fa, fb;
    logic             sign, za, zb;
    logic [EXP_W-1:0] ea, eb, exp_big, exp_small;
    logic [MAN_W:0]   mb;
    logic [MAN_W+1:0] r, r_next, q;
    logic [4:0]       cnt;
    logic             q_bit;

    assign fa = fp_unpack(reg_A);
    assign fb = fp_unpack(reg_B);
    assign busy = (state != IDLE);

    // 10-bit intermediates; only the low byte survives since range errors are excluded.
    assign exp_big   = EXP_W'(10'(ea) - 10'(eb) + 10'(EXP_BIAS));
    assign exp_small = EXP_W'(10'(ea) - 10'(eb) + 10'(EXP_BIAS - 1));

    fpdiv_restoring_step u_step (
        .r      (r),
        .mb     (mb),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        state_n = (state == IDLE) ? (start ? DIV : IDLE) :
                  (state == DIV)  ? ((cnt == 5'd24) ? NORM : DIV) : IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign        <= 1'b0;
            za          <= 1'b0;
            zb          <= 1'b0;
            ea          <= '0;
            eb          <= '0;
            mb          <= '0;
            r           <= '0;
            q           <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            out         <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                sign <= fa.sign ^ fb.sign;
                za   <= fa.zero;
                zb   <= fb.zero;
                ea   <= fa.exp;
                eb   <= fb.exp;
                mb   <= fb.man;
                r    <= {1'b0, fa.man};
                q    <= '0;
                cnt  <= '0;
            end
            if (state == DIV) begin
                r   <= r_next;
                q   <= {q[MAN_W:0], q_bit};
                cnt <= cnt + 5'd1;
            end
            if (state == NORM) begin
                done        <= 1'b1;
                div_by_zero <= zb;
                // q[24] set means ma >= mb: quotient in [1,2), otherwise in (0.5,1).
                out <= zb     ? {sign, FP32_PINF[30:0]} :
                       za     ? 32'h0 :
                       q[24]  ? {sign, exp_big, q[MAN_W:1]} :
                                {sign, exp_small, q[MAN_W-1:0]};
            end
        end
    end
endmodule

// File: tb/tb_fpdiv_iterative.sv
// tb_fpdiv_iterative: randomized self-checking bench with a truncating FP32 division model.
module tb_fpdiv_iterative;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] reg_A = '0;
    logic [31:0] reg_B = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] out_w;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [32:0] exp_q[$];
    int          acc_q[$];

    fpdiv_iterative dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .reg_A       (reg_A),
        .reg_B       (reg_B),
        .busy        (busy),
        .done        (done),
        .out         (out_w),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: real quotient ma/mb scaled by 2^24 via integer division, then normalised.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [63:0] ma, mb, q;
        int          e;
        s  = a[31] ^ b[31];
        ma = {40'h0, 1'b1, a[22:0]};
        mb = {40'h0, 1'b1, b[22:0]};
        q  = (ma << 24) / mb;
        e  = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (b[30:0] == 31'h0) return {1'b1, s, 8'hFF, 23'h0};
        if (a[30:0] == 31'h0) return 33'h0;
        if (q >= 64'h100_0000) return {1'b0, s, 8'(e), q[23:1]};
        return {1'b0, s, 8'(e - 1), q[22:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            acc_q.delete();
            chk("reset outputs", {busy, done, div_by_zero, 29'h0}, 32'h0);
            chk("reset out", out_w, 32'h0);
        end else begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected done", 32'd1, 32'd0);
                end else begin
                    logic [32:0] e;
                    int a;
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("out", out_w, e[31:0]);
                    chk("div_by_zero", {31'h0, div_by_zero}, {31'h0, e[32]});
                    chk("latency", cyc - a, 26);
                    chk("busy at done", {31'h0, busy}, 32'h0);
                end
            end else begin
                chk("busy", {31'h0, busy}, {31'h0, exp_q.size() != 0});
            end
            if (start && !busy) begin
                exp_q.push_back(model(reg_A, reg_B));
                acc_q.push_back(cyc + 1);
            end
        end
    end

    // Waits until idle with a bounded budget; garbage starts are optionally issued while busy.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit noise);
        int n = 0;
        @(posedge clk); #1;
        while (busy && n < 100) begin
            start = noise ? 1'($urandom) : 1'b0;
            reg_A = $urandom;
            reg_B = $urandom;
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("idle timeout", 32'd1, 32'd0);
        start = 1'b1;
        reg_A = a;
        reg_B = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("done timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] req, input logic dz);
        logic [32:0] m;
        m = model(a, b);
        chk({name, " model"}, m[31:0], req);
        start_op(a, b, 1'b0);
        wait_idle();
        chk({name, " out"}, out_w, req);
        chk({name, " dz"}, {31'h0, div_by_zero}, {31'h0, dz});
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [31:0] x;
        x = {1'($urandom), 8'($urandom_range(180, 70)), 23'($urandom)};
        if ($urandom_range(15, 0) == 0) x[30:0] = '0;
        return x;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset out idle", out_w, 32'h0);
        reset = 1'b1;

        run("6/2", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
        run("1/3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0);
        run("-7.5/2.5", 32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0);
        run("0/5", 32'h00000000, 32'h40A00000, 32'h00000000, 1'b0);
        run("5/0", 32'h40A00000, 32'h00000000, 32'h7F800000, 1'b1);
        run("-5/0", 32'hC0A00000, 32'h00000000, 32'hFF800000, 1'b1);
        run("1/3 again", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0);

        // Starts while busy are ignored; a start held into the done cycle is taken.
        start_op(32'h40C00000, 32'h40000000, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; reg_A = 32'h3F800000; reg_B = 32'h40400000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        start = 1'b1; reg_A = 32'h41100000; reg_B = 32'h40400000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; reg_A = 32'h41100000; reg_B = 32'h40400000;
        for (int n = 0; n < 10 && busy; n++) begin @(posedge clk); #1; end
        chk("done cycle seen", {31'h0, done}, 32'h1);
        chk("first result", out_w, 32'h40400000);
        @(posedge clk); #1;
        start = 1'b0;
        chk("restart busy", {31'h0, busy}, 32'h1);
        wait_idle();
        chk("second result", out_w, 32'h40400000);

        // Mid-operation reset aborts with no done afterwards.
        start_op(32'h3F800000, 32'h40400000, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        chk("async reset out", out_w, 32'h0);
        chk("async reset flags", {29'h0, busy, done, div_by_zero}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        begin
            int dc = 0;
            repeat (20) begin @(negedge clk); if (done || busy) dc++; end
            chk("quiet after reset", dc, 0);
        end
        run("1/3 after reset", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0);

        for (int i = 0; i < 60; i++) start_op(rnd_fp(), rnd_fp(), 1'b1);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
